smult_ctrl: RTL and testbench
=============================

Name: smult_ctrl

Overview:
- Sequencing controller that turns the unsigned 8-bit shift-add multiplier into a signed 8x8 multiplier with a valid/ready front end.
- Accepts two signed operands and converts them to magnitudes.
- Loads the multiplier datapath, then waits for its zero flag.
- Applies the result sign and holds the 16-bit signed product until the consumer takes it.
- Sits between the operand source (switch/UI logic) and the multiplier instance, which lives at the same level.

Parameters:
- SWAP_EN, 1: when 1, the smaller magnitude is routed to the multiplier's MP (shift-right) input to minimise run time; when 0, |b| is always MP.
- TIMEOUT, 12: maximum RUN-state cycles before the error abort; must be at least 9.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  controller can accept operands
- in_a  in  8  signed multiplicand, two's complement
- in_b  in  8  signed multiplier, two's complement
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result
- res_product  out  16  signed product, two's complement
- err  out  1  sticky timeout flag; cleared by reset or by the next accepted operand pair
- busy  out  1  high in every state except IDLE
- mult_load  out  1  drives the multiplier's load_Initial
- mult_mc  out  8  drives the multiplier's inMC (magnitude)
- mult_mp  out  8  drives the multiplier's inMP (magnitude)
- mult_zero  in  1  the multiplier's zeroFlag (MP shift register == 0)
- mult_product  in  16  the multiplier's unsigned product

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1; res_valid=0; res_product=0; err=0; busy=0; mult_load=0.
  - mult_mc and mult_mp are cleared to 0.
  - The multiplier has no reset; correctness never depends on its contents before a LOAD.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1, register ma=|in_a|, mb=|in_b| (8-bit unsigned; -128 maps to 128) and neg=in_a[7]^in_b[7], clear err, go to LOAD.
- Operand routing:
  - If SWAP_EN=1 and ma<mb: mult_mp=ma, mult_mc=mb.
  - Otherwise: mult_mp=mb, mult_mc=ma.
  - mult_mc and mult_mp are registered and stable from LOAD through DONE.
- LOAD:
  - Exactly one cycle with mult_load=1; next state is RUN.
  - mult_zero is ignored in LOAD because it reflects the stale shift register.
- RUN:
  - mult_load=0; a cycle counter increments each RUN cycle.
  - When mult_zero=1, capture res_product = neg ? (~mult_product+1) : mult_product, then go to DONE.
  - A zero product is never negated into a nonzero value.
  - If the counter reaches TIMEOUT with mult_zero still 0: set err=1, res_product=0, go to DONE.
- DONE:
  - res_valid=1; res_product is held stable.
  - When res_ready=1, go to IDLE; res_valid drops on the next edge.
  - in_ready=0; there is no input pipelining, so a new pair is accepted only in IDLE, on the cycle after the handshake.
- Latency:
  - Accept edge to res_valid is 2 + bitlen(mult_mp) cycles, where bitlen(0)=0.
  - Range is 2 to 10 cycles.
- Range:
  - Product magnitude is at most 16384, so the result always fits 16-bit signed.
  - -128*-128 = +16384 (0x4000); -128*127 = -16256 (0xC080).
- Simultaneous in_valid and res_ready in DONE: only the result handshake occurs; the operands wait.
- Reset mid-operation (any state): immediate return to reset values; the next accepted pair re-LOADs the datapath.

Test Plan:
1. in_a=3, in_b=-5, SWAP_EN=1 -> mult_mp=3, mult_mc=5; res_valid 4 cycles after accept; res_product=0xFFF1 (-15); err=0.
2. in_a=-128, in_b=-128 -> res_product=0x4000 after 10 cycles; with in_a=-128, in_b=127 -> 0xC080.
3. in_a=0, in_b=-7 -> mult_mp=0; res_valid after 2 cycles; res_product=0x0000 (not negated).
4. in_a=9, in_b=6 with res_ready held 0 for 5 cycles -> res_valid and res_product=0x0036 held stable; in_ready=0 throughout; IDLE one cycle after res_ready=1.
5. rst_n pulsed low during RUN of 100*100 -> all outputs at reset values immediately; next pair 2*2 -> 0x0004.
6. Multiplier model with mult_zero stuck at 0 -> err=1 and res_product=0 after TIMEOUT=12 RUN cycles; err clears on the next accepted pair.

Source files
------------

// File: rtl/smult_ctrl.sv
// Purpose : signed 8x8 front end for the unsigned shift-add multiplier (magnitudes in, sign applied on the way out).
// Latency : accept edge to res_valid = 2 + bitlen(mult_mp) cycles (2..10); 1 + TIMEOUT cycles on a timeout abort.
// Backpress: one operation in flight; in_ready only in IDLE, and the result is held in DONE until res_ready.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready/in_a/in_b signed operand pair, valid/ready
//   res_valid/res_ready         result handshake; res_product is the 16-bit signed product
//   err                         sticky timeout flag, cleared by reset or the next accepted pair
//   busy                        high outside IDLE
//   mult_load/mult_mc/mult_mp   drive the multiplier's load_Initial, inMC, inMP
//   mult_zero/mult_product      the multiplier's zeroFlag and unsigned product
module smult_ctrl #(
    parameter int SWAP_EN = 1,
    parameter int TIMEOUT = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_product,
    output logic        err,
    output logic        busy,
    output logic        mult_load,
    output logic [7:0]  mult_mc,
    output logic [7:0]  mult_mp,
    input  logic        mult_zero,
    input  logic [15:0] mult_product
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    logic          neg;
    logic [CW-1:0] cnt;

    // Magnitudes of the incoming operands; -128 maps to 8'h80 = 128.
    logic [7:0] ma, mb;
    logic       swap;

    always_comb begin
        ma   = in_a[7] ? (~in_a + 8'd1) : in_a;
        mb   = in_b[7] ? (~in_b + 8'd1) : in_b;
        // Smaller magnitude on MP means fewer shifts before the zero flag.
        swap = (SWAP_EN != 0) && (ma < mb);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            res_valid   <= 1'b0;
            res_product <= 16'd0;
            err         <= 1'b0;
            busy        <= 1'b0;
            mult_load   <= 1'b0;
            mult_mc     <= 8'd0;
            mult_mp     <= 8'd0;
            neg         <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state     <= LOAD;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        mult_load <= 1'b1;
                        err       <= 1'b0;
                        neg       <= in_a[7] ^ in_b[7];
                        mult_mc   <= swap ? mb : ma;
                        mult_mp   <= swap ? ma : mb;
                    end
                end
                LOAD: begin
                    // mult_zero still reflects the previous shift register here.
                    state     <= RUN;
                    mult_load <= 1'b0;
                    cnt       <= '0;
                end
                RUN: begin
                    if (mult_zero) begin
                        // Guard keeps a zero product from being negated.
                        res_product <= (neg && (mult_product != 16'd0)) ?
                                       (~mult_product + 16'd1) : mult_product;
                        res_valid   <= 1'b1;
                        state       <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        err         <= 1'b1;
                        res_product <= 16'd0;
                        res_valid   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    // A pending in_valid waits until IDLE, one cycle after this handshake.
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_smult_ctrl.sv
module tb_smult_ctrl;

    localparam int SWAP_EN = 1;
    localparam int TIMEOUT = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = 8'd0;
    logic [7:0]  in_b = 8'd0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_product;
    logic        err;
    logic        busy;
    logic        mult_load;
    logic [7:0]  mult_mc;
    logic [7:0]  mult_mp;
    logic        mult_zero;
    logic [15:0] mult_product;

    int total = 0;
    int bad   = 0;

    smult_ctrl #(.SWAP_EN(SWAP_EN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_product(res_product),
        .err(err), .busy(busy),
        .mult_load(mult_load), .mult_mc(mult_mc), .mult_mp(mult_mp),
        .mult_zero(mult_zero), .mult_product(mult_product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int bitlen(input int v);
        int n = 0;
        while ((v >> n) != 0) n++;
        return n;
    endfunction

    // Shift-add multiplier stand-in: after load, k shifts have consumed the k low bits of MP.
    logic       stuck = 1'b0;
    logic [7:0] bm_mc = 8'd0;
    logic [7:0] bm_mp = 8'd0;
    int         bm_k  = 0;

    always @(posedge clk) begin
        if (mult_load) begin
            bm_mc <= mult_mc;
            bm_mp <= mult_mp;
            bm_k  <= 0;
        end else if (bm_k < 9) begin
            bm_k <= bm_k + 1;
        end
    end

    always_comb begin
        mult_zero    = stuck ? 1'b0 : ((int'(bm_mp) >> bm_k) == 0);
        mult_product = 16'(int'(bm_mc) * (int'(bm_mp) & ((1 << bm_k) - 1)));
    end

    // Transaction-level reference: m_d counts edges since the accept edge.
    logic        m_active;
    int          m_d, m_lat;
    logic [15:0] m_prod, m_fin;
    logic        m_err, m_efin;
    logic [7:0]  m_mc, m_mp;
    int          sa, sb, ma, mb, mc, mp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0; m_d <= 0; m_lat <= 0;
            m_prod <= 16'd0; m_fin <= 16'd0; m_err <= 1'b0; m_efin <= 1'b0;
            m_mc <= 8'd0; m_mp <= 8'd0;
        end else if (!m_active) begin
            if (in_valid) begin
                sa = int'($signed(in_a));
                sb = int'($signed(in_b));
                ma = (sa < 0) ? -sa : sa;
                mb = (sb < 0) ? -sb : sb;
                if (SWAP_EN != 0 && ma < mb) begin mp = ma; mc = mb; end
                else begin mp = mb; mc = ma; end
                m_mc <= 8'(mc); m_mp <= 8'(mp);
                m_active <= 1'b1; m_d <= 0; m_err <= 1'b0;
                if (stuck) begin
                    m_lat <= 1 + TIMEOUT; m_fin <= 16'd0; m_efin <= 1'b1;
                end else begin
                    m_lat <= 2 + bitlen(mp); m_fin <= 16'(sa * sb); m_efin <= 1'b0;
                end
            end
        end else if (m_d >= m_lat && res_ready) begin
            m_active <= 1'b0;
        end else begin
            m_d <= m_d + 1;
            if (m_d + 1 == m_lat) begin
                m_prod <= m_fin;
                m_err  <= m_efin;
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready",    int'(in_ready),    m_active ? 0 : 1);
        chk("busy",        int'(busy),        m_active ? 1 : 0);
        chk("res_valid",   int'(res_valid),   (m_active && m_d >= m_lat) ? 1 : 0);
        chk("mult_load",   int'(mult_load),   (m_active && m_d == 0) ? 1 : 0);
        chk("res_product", int'(res_product), int'(m_prod));
        chk("err",         int'(err),         int'(m_err));
        chk("mult_mc",     int'(mult_mc),     int'(m_mc));
        chk("mult_mp",     int'(mult_mp),     int'(m_mp));
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] a, input logic [7:0] b);
        in_a = a; in_b = b; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_res(input string name, input int lat, input int prod, input int e);
        int d = 0;
        while (!res_valid && d < 30) begin
            tick();
            d++;
        end
        if (!res_valid) chk({name, "_timeout"}, 0, 1);
        chk({name, "_lat"},  d, lat);
        chk({name, "_prod"}, int'(res_product), prod);
        chk({name, "_err"},  int'(err), e);
    endtask

    task automatic take();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        tick(); tick();
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_prod",     int'(res_product), 0);
        chk("rst_busy",     int'(busy), 0);
        rst_n = 1'b1;
        tick();

        // 3 * -5: swap puts 3 on MP
        accept(8'd3, 8'hFB);
        chk("t1_mp", int'(mult_mp), 3);
        chk("t1_mc", int'(mult_mc), 5);
        wait_res("t1", 4, 16'hFFF1, 0);
        take();

        // -128 * -128 and -128 * 127
        accept(8'h80, 8'h80);
        wait_res("t2a", 10, 16'h4000, 0);
        take();
        accept(8'h80, 8'h7F);
        wait_res("t2b", 9, 16'hC080, 0);
        take();

        // 0 * -7: zero product stays zero
        accept(8'd0, 8'hF9);
        chk("t3_mp", int'(mult_mp), 0);
        wait_res("t3", 2, 16'h0000, 0);
        take();

        // 9 * 6 held for 5 cycles, then handshake alongside a new in_valid
        accept(8'd9, 8'd6);
        wait_res("t4", 5, 16'h0036, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold_vld",  int'(res_valid), 1);
            chk("t4_hold_prod", int'(res_product), 16'h0036);
            chk("t4_hold_rdy",  int'(in_ready), 0);
        end
        in_a = 8'd1; in_b = 8'd1; in_valid = 1'b1; res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("t4_idle_rdy", int'(in_ready), 1);
        chk("t4_idle_vld", int'(res_valid), 0);
        accept(8'd1, 8'd1);
        wait_res("t4b", 3, 16'h0001, 0);
        take();

        // reset in the middle of 100 * 100
        accept(8'd100, 8'd100);
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_rdy",  int'(in_ready), 1);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_prod", int'(res_product), 0);
        chk("t5_rst_mc",   int'(mult_mc), 0);
        tick();
        rst_n = 1'b1;
        tick();
        accept(8'd2, 8'd2);
        wait_res("t5", 4, 16'h0004, 0);
        take();

        // stuck zero flag: timeout abort, then err clears on the next accept
        stuck = 1'b1;
        accept(8'd5, 8'd5);
        wait_res("t6", 13, 16'h0000, 1);
        take();
        chk("t6_err_sticky", int'(err), 1);
        stuck = 1'b0;
        accept(8'hFD, 8'd4);
        chk("t6_err_clr", int'(err), 0);
        wait_res("t6b", 4, 16'hFFF4, 0);
        take();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
